// File: rtl/traffic_phase_ctrl.sv
//==============================================================================
// traffic_phase_ctrl : fixed-time RED/GREEN/YELLOW sequencer with pedestrian
//                      green truncation, night blink mode and maintenance hold.
// Revision: 1.0
//==============================================================================
`default_nettype none

module traffic_phase_ctrl #(
  parameter int RED_T    = 25,
  parameter int GREEN_T  = 30,
  parameter int YELLOW_T = 5,
  parameter int PED_MIN  = 5
) (
  input  logic       clk_1Hz,
  input  logic       i_rst_n,
  input  logic       i_ped_req,
  input  logic       i_night,
  input  logic       i_hold,
  output logic [1:0] o_phase,
  output logic [5:0] o_remain,
  output logic       o_phase_start,
  output logic       o_blink,
  output logic       o_ped_pending
);

  localparam logic [5:0] c_RED_T    = 6'(RED_T);
  localparam logic [5:0] c_GREEN_T  = 6'(GREEN_T);
  localparam logic [5:0] c_YELLOW_T = 6'(YELLOW_T);
  localparam logic [5:0] c_PED_MIN  = 6'(PED_MIN);

  // State encoding doubles as the o_phase code.
  typedef enum logic [1:0] {
    S_NIGHT  = 2'b00,
    S_RED    = 2'b01,
    S_YELLOW = 2'b10,
    S_GREEN  = 2'b11
  } state_t;

  state_t     r_state;
  logic [5:0] r_remain;
  logic       r_entered;
  logic       r_phase_start;
  logic       r_blink;
  logic       r_ped;

  always_ff @(posedge clk_1Hz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_RED;
      r_remain      <= c_RED_T;
      r_entered     <= 1'b1;
      r_phase_start <= 1'b0;
      r_blink       <= 1'b0;
      r_ped         <= 1'b0;
    end else begin
      // r_entered marks a phase entry on this edge; the pulse appears one tick later.
      r_phase_start <= r_entered;
      r_entered     <= 1'b0;

      if ((r_state == S_GREEN || r_state == S_YELLOW) && i_ped_req)
        r_ped <= 1'b1;

      if (i_night) begin
        r_blink  <= (r_state == S_NIGHT) ? ~r_blink : 1'b1;
        r_remain <= 6'd0;
        if (r_state != S_NIGHT) begin
          r_state   <= S_NIGHT;
          r_entered <= 1'b1;
        end
      end else if (r_state == S_NIGHT) begin
        r_state   <= S_RED;
        r_remain  <= c_RED_T;
        r_blink   <= 1'b0;
        r_ped     <= 1'b0;
        r_entered <= 1'b1;
      end else if (!i_hold) begin
        if (r_remain <= 6'd1) begin
          r_entered <= 1'b1;
          case (r_state)
            S_RED: begin
              r_state  <= S_GREEN;
              r_remain <= c_GREEN_T;
            end
            S_GREEN: begin
              r_state  <= S_YELLOW;
              r_remain <= c_YELLOW_T;
            end
            default: begin
              // Clearing here overrides any same-tick latch above.
              r_state  <= S_RED;
              r_remain <= c_RED_T;
              r_ped    <= 1'b0;
            end
          endcase
        end else if (r_state == S_GREEN && r_ped && r_remain > c_PED_MIN) begin
          r_remain <= c_PED_MIN;
        end else begin
          r_remain <= r_remain - 6'd1;
        end
      end
    end
  end

  assign o_phase       = r_state;
  assign o_remain      = r_remain;
  assign o_phase_start = r_phase_start;
  assign o_blink       = r_blink;
  assign o_ped_pending = r_ped;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
//==============================================================================
// tb_traffic_phase_ctrl : directed self-checking bench for traffic_phase_ctrl.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_traffic_phase_ctrl;

  localparam logic [1:0] P_NIGHT  = 2'b00;
  localparam logic [1:0] P_RED    = 2'b01;
  localparam logic [1:0] P_YELLOW = 2'b10;
  localparam logic [1:0] P_GREEN  = 2'b11;

  logic       clk_1Hz = 1'b0;
  logic       i_rst_n;
  logic       i_ped_req;
  logic       i_night;
  logic       i_hold;
  logic [1:0] o_phase;
  logic [5:0] o_remain;
  logic       o_phase_start;
  logic       o_blink;
  logic       o_ped_pending;

  int n_tests = 0;
  int n_fail  = 0;

  traffic_phase_ctrl dut (
    .clk_1Hz      (clk_1Hz),
    .i_rst_n      (i_rst_n),
    .i_ped_req    (i_ped_req),
    .i_night      (i_night),
    .i_hold       (i_hold),
    .o_phase      (o_phase),
    .o_remain     (o_remain),
    .o_phase_start(o_phase_start),
    .o_blink      (o_blink),
    .o_ped_pending(o_ped_pending)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  task automatic tick();
    @(posedge clk_1Hz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] ph, input logic [5:0] rm,
                           input logic pend);
    chk({tag, ".phase"}, 32'(o_phase), 32'(ph));
    chk({tag, ".remain"}, 32'(o_remain), 32'(rm));
    chk({tag, ".pend"}, 32'(o_ped_pending), 32'(pend));
  endtask

  task automatic run_until(input string tag, input logic [1:0] ph, input logic [5:0] rm);
    int n = 0;
    while (!(o_phase === ph && o_remain === rm) && n < 100) begin
      tick();
      n++;
    end
    n_tests++;
    assert (o_phase === ph && o_remain === rm) else begin
      n_fail++;
      $error("FAIL %s timeout phase=%0d remain=%0d expected phase=%0d remain=%0d",
             tag, o_phase, o_remain, ph, rm);
    end
  endtask

  initial begin
    logic [1:0] e_ph;
    logic [5:0] e_rm;
    logic       e_ps;

    i_rst_n   = 1'b0;
    i_ped_req = 1'b0;
    i_night   = 1'b0;
    i_hold    = 1'b0;
    tick();
    tick();
    chk_state("reset", P_RED, 6'd25, 1'b0);
    chk("reset.ps", 32'(o_phase_start), 32'd0);
    chk("reset.blink", 32'(o_blink), 32'd0);
    i_rst_n = 1'b1;

    // Default free-running cycle
    for (int t = 1; t <= 61; t++) begin
      tick();
      if (t <= 24) begin e_ph = P_RED; e_rm = 6'(25 - t); end
      else if (t <= 54) begin e_ph = P_GREEN; e_rm = 6'(55 - t); end
      else if (t <= 59) begin e_ph = P_YELLOW; e_rm = 6'(60 - t); end
      else begin e_ph = P_RED; e_rm = 6'(85 - t); end
      e_ps = (t == 1 || t == 26 || t == 56 || t == 61);
      chk($sformatf("cyc%0d.phase", t), 32'(o_phase), 32'(e_ph));
      chk($sformatf("cyc%0d.remain", t), 32'(o_remain), 32'(e_rm));
      chk($sformatf("cyc%0d.ps", t), 32'(o_phase_start), 32'(e_ps));
    end

    // Pedestrian truncation from GREEN 20
    run_until("to_g20", P_GREEN, 6'd20);
    i_ped_req = 1'b1;
    tick();
    i_ped_req = 1'b0;
    chk_state("ped20.req", P_GREEN, 6'd19, 1'b1);
    tick();
    chk_state("ped20.trunc", P_GREEN, 6'd5, 1'b1);
    for (int r = 4; r >= 1; r--) begin
      tick();
      chk_state($sformatf("ped20.g%0d", r), P_GREEN, 6'(r), 1'b1);
    end
    for (int r = 5; r >= 1; r--) begin
      tick();
      chk_state($sformatf("ped20.y%0d", r), P_YELLOW, 6'(r), 1'b1);
    end
    // Request on the RED-entry tick is dropped
    i_ped_req = 1'b1;
    tick();
    chk_state("ped20.red", P_RED, 6'd25, 1'b0);
    tick();
    chk_state("ped.in_red", P_RED, 6'd24, 1'b0);
    i_ped_req = 1'b0;

    // Late request: no truncation below PED_MIN
    run_until("to_g3", P_GREEN, 6'd3);
    i_ped_req = 1'b1;
    tick();
    i_ped_req = 1'b0;
    chk_state("ped3.g2", P_GREEN, 6'd2, 1'b1);
    tick();
    chk_state("ped3.g1", P_GREEN, 6'd1, 1'b1);
    tick();
    chk_state("ped3.y5", P_YELLOW, 6'd5, 1'b1);
    run_until("ped3.to_red", P_RED, 6'd25);
    chk("ped3.red.pend", 32'(o_ped_pending), 32'd0);

    // Night mode from YELLOW 4
    run_until("to_y4", P_YELLOW, 6'd4);
    i_night = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("night%0d.phase", k), 32'(o_phase), 32'(P_NIGHT));
      chk($sformatf("night%0d.remain", k), 32'(o_remain), 32'd0);
      chk($sformatf("night%0d.blink", k), 32'(o_blink), 32'((k % 2) == 0));
    end
    i_night = 1'b0;
    tick();
    chk_state("night.exit", P_RED, 6'd25, 1'b0);
    chk("night.exit.blink", 32'(o_blink), 32'd0);
    tick();
    chk("night.exit.ps", 32'(o_phase_start), 32'd1);
    chk("night.exit.rm", 32'(o_remain), 32'd24);

    // Hold in GREEN 12, request latched during hold, night overrides hold
    run_until("to_g12", P_GREEN, 6'd12);
    i_hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i_ped_req = (k == 5);
      tick();
      chk_state($sformatf("hold%0d", k), P_GREEN, 6'd12, (k >= 5));
    end
    i_ped_req = 1'b0;
    i_night = 1'b1;
    tick();
    chk("hold.night.phase", 32'(o_phase), 32'(P_NIGHT));
    chk("hold.night.blink", 32'(o_blink), 32'd1);
    i_night = 1'b0;
    i_hold  = 1'b0;
    tick();
    chk_state("hold.release", P_RED, 6'd25, 1'b0);

    // Asynchronous reset mid-GREEN with a pending request
    run_until("to_g8", P_GREEN, 6'd8);
    i_ped_req = 1'b1;
    tick();
    i_ped_req = 1'b0;
    chk_state("arst.pre", P_GREEN, 6'd7, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_state("arst.now", P_RED, 6'd25, 1'b0);
    chk("arst.ps", 32'(o_phase_start), 32'd0);
    #3;
    i_rst_n = 1'b1;
    tick();
    chk_state("arst.after", P_RED, 6'd24, 1'b0);
    chk("arst.after.ps", 32'(o_phase_start), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
